// File: rtl/idli_ex_serial_m.sv
// Slice-serial execution unit: DATA_W-bit operands processed SLICE_W bits per cycle, LSB slice first.
// Holds the GPR file, a carry-chained ALU (ADD/SUB/AND/OR/XOR) and the {Z,C} flags.
module idli_ex_serial_m #(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4,
  parameter int NREGS   = 16,
  localparam int N      = DATA_W / SLICE_W,
  localparam int REG_W  = $clog2(NREGS),
  localparam int CTR_W  = $clog2(N)
) (
  input  logic               i_ex_gck,
  input  logic               i_ex_rst_n,
  input  logic               i_ex_op_vld,
  output logic               o_ex_op_acp,
  input  logic [2:0]         i_ex_alu_op,
  input  logic [REG_W-1:0]   i_ex_a,
  input  logic [REG_W-1:0]   i_ex_b,
  input  logic [REG_W-1:0]   i_ex_c,
  input  logic [1:0]         i_ex_b_src,
  input  logic               i_ex_c_src,
  input  logic               i_ex_wr_en,
  input  logic [SLICE_W-1:0] i_ex_imm,
  input  logic [SLICE_W-1:0] i_ex_pc,
  output logic [SLICE_W-1:0] o_ex_res,
  output logic               o_ex_res_vld,
  output logic               o_ex_res_last,
  output logic [1:0]         o_ex_flags,
  input  logic [REG_W-1:0]   i_ex_dbg_reg,
  output logic [DATA_W-1:0]  o_ex_dbg_data
);

  localparam logic [CTR_W-1:0] LAST_CTR = CTR_W'(N - 1);

  logic               r_vld;
  logic [CTR_W-1:0]   r_ctr;
  logic               r_carry;
  logic               r_zacc;
  logic [1:0]         r_flags;
  logic [2:0]         r_alu_op;
  logic [REG_W-1:0]   r_a;
  logic [REG_W-1:0]   r_b;
  logic [REG_W-1:0]   r_c;
  logic [1:0]         r_b_src;
  logic               r_c_src;
  logic               r_wr_en;
  logic [DATA_W-1:0]  r_gpr [NREGS];

  logic               w_first;
  logic               w_last;
  logic [31:0]        w_lsb;
  logic [DATA_W-1:0]  w_b_word;
  logic [DATA_W-1:0]  w_c_word;
  logic [SLICE_W-1:0] w_lhs;
  logic [SLICE_W-1:0] w_rhs;
  logic               w_is_sub;
  logic               w_is_logic;
  logic               w_cin;
  logic [SLICE_W:0]   w_sum;
  logic [SLICE_W-1:0] w_res;
  logic               w_cout;
  logic               w_zacc_nxt;

  assign w_first     = (r_ctr == {CTR_W{1'b0}});
  assign w_last      = (r_ctr == LAST_CTR);
  assign w_lsb       = 32'(r_ctr) * 32'(SLICE_W);
  assign o_ex_op_acp = !r_vld || w_last;

  // R0 is hardwired to zero on every read port
  assign w_b_word      = (r_b == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : r_gpr[r_b];
  assign w_c_word      = (r_c == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : r_gpr[r_c];
  assign o_ex_dbg_data = (i_ex_dbg_reg == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : r_gpr[i_ex_dbg_reg];

  // Operand selection and slice ALU for the current execute cycle
  always_comb begin
    w_lhs      = {SLICE_W{1'b0}};
    w_rhs      = {SLICE_W{1'b0}};
    w_res      = {SLICE_W{1'b0}};
    w_cout     = 1'b0;
    w_is_sub   = (r_alu_op == 3'd1);
    w_is_logic = (r_alu_op == 3'd2) || (r_alu_op == 3'd3) || (r_alu_op == 3'd4);
    case (r_b_src)
      2'd0:    w_lhs = w_b_word[w_lsb +: SLICE_W];
      2'd2:    w_lhs = i_ex_pc;
      default: w_lhs = {SLICE_W{1'b0}};
    endcase
    if (r_c_src) begin
      w_rhs = i_ex_imm;
    end else begin
      w_rhs = w_c_word[w_lsb +: SLICE_W];
    end
    w_cin = w_first ? w_is_sub : r_carry;
    w_sum = {1'b0, w_lhs} + {1'b0, (w_is_sub ? ~w_rhs : w_rhs)} + {{SLICE_W{1'b0}}, w_cin};
    case (r_alu_op)
      3'd2:    w_res = w_lhs & w_rhs;
      3'd3:    w_res = w_lhs | w_rhs;
      3'd4:    w_res = w_lhs ^ w_rhs;
      default: begin
        w_res  = w_sum[SLICE_W-1:0];
        w_cout = w_sum[SLICE_W];
      end
    endcase
    w_zacc_nxt = (w_first ? 1'b1 : r_zacc) & (w_res == {SLICE_W{1'b0}});
  end

  // Result slice is only presented while an op is executing
  always_comb begin
    if (r_vld) begin
      o_ex_res      = w_res;
      o_ex_res_vld  = 1'b1;
      o_ex_res_last = w_last;
    end else begin
      o_ex_res      = {SLICE_W{1'b0}};
      o_ex_res_vld  = 1'b0;
      o_ex_res_last = 1'b0;
    end
  end

  assign o_ex_flags = r_flags;

  // Op capture, slice counter, carry/zero chain and flags
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      r_vld    <= 1'b0;
      r_ctr    <= {CTR_W{1'b0}};
      r_carry  <= 1'b0;
      r_zacc   <= 1'b1;
      r_flags  <= 2'b00;
      r_alu_op <= 3'd0;
      r_a      <= {REG_W{1'b0}};
      r_b      <= {REG_W{1'b0}};
      r_c      <= {REG_W{1'b0}};
      r_b_src  <= 2'd0;
      r_c_src  <= 1'b0;
      r_wr_en  <= 1'b0;
    end else begin
      if (o_ex_op_acp) begin
        r_vld    <= i_ex_op_vld;
        r_alu_op <= i_ex_alu_op;
        r_a      <= i_ex_a;
        r_b      <= i_ex_b;
        r_c      <= i_ex_c;
        r_b_src  <= i_ex_b_src;
        r_c_src  <= i_ex_c_src;
        r_wr_en  <= i_ex_wr_en;
      end
      // N is a power of two, so the counter wraps to 0 on its own after the last slice
      if (r_vld) begin
        r_ctr   <= r_ctr + {{(CTR_W-1){1'b0}}, 1'b1};
        r_carry <= w_cout;
        r_zacc  <= w_zacc_nxt;
        if (w_last) begin
          r_flags[1] <= w_zacc_nxt;
          if (!w_is_logic) begin
            r_flags[0] <= w_cout;
          end
        end
      end
    end
  end

  // Slice writeback; GPRs are deliberately not reset so completed slices survive a reset
  always_ff @(posedge i_ex_gck) begin
    if (r_vld && r_wr_en && (r_a != {REG_W{1'b0}})) begin
      r_gpr[r_a][w_lsb +: SLICE_W] <= w_res;
    end
  end

endmodule

// File: tb/tb_idli_ex_serial_m.sv
// Directed bench for idli_ex_serial_m: a 16-bit instance for most vectors and a
// 32-bit instance to confirm the slice count scales with DATA_W.
module tb_idli_ex_serial_m;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_vld, op_vld32;
  logic [2:0]  alu_op;
  logic [3:0]  a, b, c, dbg;
  logic [1:0]  b_src;
  logic        c_src, wr_en;
  logic [3:0]  imm, pc;

  logic        acp, res_vld, res_last;
  logic [3:0]  res;
  logic [1:0]  flags;
  logic [15:0] dbg_data;
  logic        acp32, res_vld32, res_last32;
  logic [3:0]  res32;
  logic [1:0]  flags32;
  logic [31:0] dbg_data32;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  idli_ex_serial_m #(.DATA_W(16), .SLICE_W(4), .NREGS(16)) u_dut (
    .i_ex_gck(clk), .i_ex_rst_n(rst_n), .i_ex_op_vld(op_vld), .o_ex_op_acp(acp),
    .i_ex_alu_op(alu_op), .i_ex_a(a), .i_ex_b(b), .i_ex_c(c),
    .i_ex_b_src(b_src), .i_ex_c_src(c_src), .i_ex_wr_en(wr_en),
    .i_ex_imm(imm), .i_ex_pc(pc), .o_ex_res(res), .o_ex_res_vld(res_vld),
    .o_ex_res_last(res_last), .o_ex_flags(flags),
    .i_ex_dbg_reg(dbg), .o_ex_dbg_data(dbg_data)
  );

  idli_ex_serial_m #(.DATA_W(32), .SLICE_W(4), .NREGS(16)) u_dut32 (
    .i_ex_gck(clk), .i_ex_rst_n(rst_n), .i_ex_op_vld(op_vld32), .o_ex_op_acp(acp32),
    .i_ex_alu_op(alu_op), .i_ex_a(a), .i_ex_b(b), .i_ex_c(c),
    .i_ex_b_src(b_src), .i_ex_c_src(c_src), .i_ex_wr_en(wr_en),
    .i_ex_imm(imm), .i_ex_pc(pc), .o_ex_res(res32), .o_ex_res_vld(res_vld32),
    .o_ex_res_last(res_last32), .o_ex_flags(flags32),
    .i_ex_dbg_reg(dbg), .o_ex_dbg_data(dbg_data32)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [3:0] r, input logic [15:0] exp);
    dbg = r;
    #1;
    check_eq(tag, 64'(dbg_data), 64'(exp));
  endtask

  task automatic set_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic [1:0] bs, input logic cs, input logic we);
    alu_op = op; a = ra; b = rb; c = rc; b_src = bs; c_src = cs; wr_en = we;
  endtask

  // Issue one op on the 16-bit unit (entered just after a posedge, unit idle) and check each slice
  task automatic run_op(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic [1:0] bs, input logic cs, input logic we,
                        input logic [15:0] imm_w, input logic [15:0] pc_w,
                        input logic [15:0] exp_w, input string tag);
    set_op(op, ra, rb, rc, bs, cs, we);
    op_vld = 1'b1;
    @(posedge clk); #1;
    op_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imm = imm_w[4*k +: 4];
      pc  = pc_w[4*k +: 4];
      @(negedge clk);
      check_eq($sformatf("%s_res%0d", tag, k), 64'(res), 64'(exp_w[4*k +: 4]));
      check_eq($sformatf("%s_vld%0d", tag, k), 64'(res_vld), 64'd1);
      check_eq($sformatf("%s_last%0d", tag, k), 64'(res_last), 64'(k == 3));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] w32;
    rst_n = 1'b0; op_vld = 1'b0; op_vld32 = 1'b0; dbg = 4'd0;
    imm = 4'd0; pc = 4'd0;
    set_op(3'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_acp", 64'(acp), 64'd1);
    check_eq("rst_vld", 64'(res_vld), 64'd0);
    check_eq("rst_last", 64'(res_last), 64'd0);
    check_eq("rst_res", 64'(res), 64'd0);
    check_eq("rst_flags", 64'(flags), 64'd0);
    @(posedge clk); #1;

    // Test 1: r1 = 0 + imm 0x1234
    run_op(3'd0, 4'd1, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h1234, "t1");
    check_reg("t1_r1", 4'd1, 16'h1234);
    check_eq("t1_flags", 64'(flags), 64'd0);

    // Test 2: r2 = r1 - r1, then r6 = 1 - 2
    run_op(3'd1, 4'd2, 4'd1, 4'd1, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, "t2a");
    check_reg("t2a_r2", 4'd2, 16'h0000);
    check_eq("t2a_flags", 64'(flags), 64'd3);
    run_op(3'd0, 4'd5, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0001, "t2b");
    run_op(3'd1, 4'd6, 4'd5, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0002, 16'h0000, 16'hFFFF, "t2c");
    check_reg("t2c_r6", 4'd6, 16'hFFFF);
    check_eq("t2c_flags", 64'(flags), 64'd0);

    // PC as LHS with a reserved op code that must behave as ADD
    run_op(3'd7, 4'd9, 4'd0, 4'd0, 2'd2, 1'b1, 1'b1, 16'h0234, 16'h1000, 16'h1234, "pc");
    check_reg("pc_r9", 4'd9, 16'h1234);

    // Test 3: carry ripple through every slice, then XOR leaves C alone
    run_op(3'd0, 4'd3, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, "t3a");
    run_op(3'd0, 4'd7, 4'd3, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'h0000, "t3b");
    check_eq("t3b_flags", 64'(flags), 64'd3);
    run_op(3'd4, 4'd8, 4'd3, 4'd0, 2'd0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'hFFFE, "t3c");
    check_reg("t3c_r8", 4'd8, 16'hFFFE);
    check_eq("t3c_flags", 64'(flags), 64'd1);

    // Test 5: reset during slice 2 of r4 = 0 + 0x00AB
    set_op(3'd0, 4'd4, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1);
    op_vld = 1'b1;
    @(posedge clk); #1;
    op_vld = 1'b0; imm = 4'hB;
    @(posedge clk); #1;
    imm = 4'hA;
    @(posedge clk); #1;
    imm = 4'h0;
    @(negedge clk);
    check_eq("t5_pre_vld", 64'(res_vld), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_vld", 64'(res_vld), 64'd0);
    check_eq("t5_rst_acp", 64'(acp), 64'd1);
    check_eq("t5_rst_flags", 64'(flags), 64'd0);
    check_eq("t5_rst_res", 64'(res), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dbg = 4'd4;
    #1;
    check_eq("t5_r4_kept", 64'(dbg_data[7:0]), 64'h00AB);
    @(negedge clk);
    check_eq("t5_idle_vld", 64'(res_vld), 64'd0);
    @(posedge clk); #1;
    run_op(3'd0, 4'd10, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 16'h00C5, 16'h0000, 16'h00C5, "t5post");

    // Test 4: three dependent back-to-back r1 = r1 + 1
    run_op(3'd2, 4'd1, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, "t4init");
    set_op(3'd0, 4'd1, 4'd1, 4'd0, 2'd0, 1'b1, 1'b1);
    op_vld = 1'b1; imm = 4'd0;
    @(negedge clk);
    check_eq("t4_acp_idle", 64'(acp), 64'd1);
    @(posedge clk); #1;
    for (int j = 0; j < 12; j++) begin
      imm = ((j % 4) == 0) ? 4'd1 : 4'd0;
      op_vld = (j < 8);
      @(negedge clk);
      check_eq($sformatf("t4_vld%0d", j), 64'(res_vld), 64'd1);
      check_eq($sformatf("t4_acp%0d", j), 64'(acp), 64'((j % 4) == 3));
      check_eq($sformatf("t4_res%0d", j), 64'(res), ((j % 4) == 0) ? 64'(j / 4 + 1) : 64'd0);
      @(posedge clk); #1;
    end
    op_vld = 1'b0;
    @(negedge clk);
    check_eq("t4_end_vld", 64'(res_vld), 64'd0);
    check_eq("t4_end_acp", 64'(acp), 64'd1);
    @(posedge clk); #1;
    check_reg("t4_r1", 4'd1, 16'h0003);

    // Test 6: writes to r0 are dropped
    run_op(3'd0, 4'd0, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 16'h5555, 16'h0000, 16'h5555, "t6a");
    check_reg("t6_r0", 4'd0, 16'h0000);

    // Test 6b: 32-bit instance runs eight slices
    w32 = 32'h5678_1234;
    set_op(3'd0, 4'd1, 4'd0, 4'd0, 2'd1, 1'b1, 1'b1);
    op_vld32 = 1'b1;
    @(posedge clk); #1;
    op_vld32 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      imm = w32[4*k +: 4];
      @(negedge clk);
      check_eq($sformatf("t6b_res%0d", k), 64'(res32), 64'(w32[4*k +: 4]));
      check_eq($sformatf("t6b_vld%0d", k), 64'(res_vld32), 64'd1);
      check_eq($sformatf("t6b_last%0d", k), 64'(res_last32), 64'(k == 7));
      @(posedge clk); #1;
    end
    dbg = 4'd1;
    #1;
    check_eq("t6b_r1", 64'(dbg_data32), 64'h5678_1234);
    check_eq("t6b_flags", 64'(flags32), 64'd0);
    check_eq("t6b_acp", 64'(acp32), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
